// File: rtl/rca_s_pkg.sv
// Shared constants for the rca_s ripple-carry adder/subtractor.
// Holds the default operand width and the add/subtract mode encodings.
package rca_s_pkg;

    localparam int RCA_S_WIDTH_DEF = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/rca_s_full_adder.sv
// One-bit full adder built from XOR/AND/OR gates; one ripple stage of rca_s.
// Purely combinational, no flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;
    logic g;
    logic pc;

    assign p    = a ^ b;
    assign g    = a & b;
    assign pc   = p & cin;
    assign sum  = p ^ cin;
    assign cout = g | pc;

endmodule

// File: rtl/rca_s.sv
// Registered ripple-carry add/subtract, one-cycle latency, one op per cycle, no backpressure.
// Optional signed-overflow output OVF is present only when RCA_S_OVF_EN is defined.
module rca_s
    import rca_s_pkg::*;
#(
    parameter int WIDTH = RCA_S_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             M,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             Co,
`ifdef RCA_S_OVF_EN
    output logic             OVF,
`endif
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] b_eff;

    // Subtraction is A + ~B + ~Cin: invert B and the incoming carry/borrow.
    assign b_eff    = B ^ {WIDTH{M}};
    assign carry[0] = Cin ^ M;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (A[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    logic [WIDTH-1:0] s_d, s_q;
    logic             co_d, co_q;
    logic             vld_d, vld_q;

    always_comb begin
        s_d   = s_q;
        co_d  = co_q;
        vld_d = 1'b0;
        if (in_valid) begin
            s_d   = sum;
            co_d  = carry[WIDTH];
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            co_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            co_q  <= co_d;
            vld_q <= vld_d;
        end
    end

    assign S         = s_q;
    assign Co        = co_q;
    assign out_valid = vld_q;

`ifdef RCA_S_OVF_EN
    logic ovf_d, ovf_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_rca_s.sv
// Scoreboard bench for rca_s: stimulus pushes expected results, a negedge monitor pops and compares.
// Covers RCA_S_OVF_EN builds as well; OVF is compared only when the macro is defined.
module tb_rca_s;
    import rca_s_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         M;
    logic         in_valid;
    logic [W-1:0] S;
    logic         Co;
    logic         out_valid;
`ifdef RCA_S_OVF_EN
    logic         OVF;
`endif

    rca_s #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .M         (M),
        .in_valid  (in_valid),
        .S         (S),
        .Co        (Co),
`ifdef RCA_S_OVF_EN
        .OVF       (OVF),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks;
    int   errors;

    // Reference: add is A+B+Cin, subtract is A+~B+(1-Cin), both over W+1 bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic m);
        exp_t         e;
        logic [W:0]   r;
        logic [W-1:0] bb;
        bb = (m == MODE_SUB) ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + ((m == MODE_SUB) ? {{W{1'b0}}, ~cin} : {{W{1'b0}}, cin});
        e.s   = r[W-1:0];
        e.co  = r[W];
        e.ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: out_valid with S=%b Co=%b and nothing expected", S, Co);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (S !== e.s || Co !== e.co) begin
                    errors++;
                    $display("FAIL result: got S=%b Co=%b, expected S=%b Co=%b", S, Co, e.s, e.co);
                end
`ifdef RCA_S_OVF_EN
                else if (OVF !== e.ovf) begin
                    errors++;
                    $display("FAIL ovf: got %b, expected %b (S=%b)", OVF, e.ovf, S);
                end
`endif
            end
        end
    end

    // Expected values given by hand: {s, co, ovf}.
    task automatic op_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic m, input exp_t e);
        A = a; B = b; Cin = cin; M = m; in_valid = 1'b1;
        sb.push_back(e);
        last_exp = e;
        @(posedge clk); #1;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic m);
        op_exp(a, b, cin, m, model(a, b, cin, m));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; in_valid = 1'b0;
        A = '0; B = '0; Cin = 1'b0; M = MODE_ADD;
        #3;
        cmp("reset_S", {4'h0, S}, 8'h00);
        cmp("reset_Co", {7'h0, Co}, 8'h00);
        cmp("reset_vld", {7'h0, out_valid}, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, expected {S, Co, OVF} worked out by hand.
        op_exp(4'b0000, 4'b0000, 1'b0, MODE_ADD, {4'b0000, 1'b0, 1'b0});
        op_exp(4'b1111, 4'b0011, 1'b0, MODE_SUB, {4'b1100, 1'b1, 1'b0});
        op_exp(4'b1111, 4'b0011, 1'b0, MODE_ADD, {4'b0010, 1'b1, 1'b0});
        op_exp(4'b1001, 4'b0101, 1'b0, MODE_SUB, {4'b0100, 1'b1, 1'b1});
        op_exp(4'b1000, 4'b1010, 1'b0, MODE_ADD, {4'b0010, 1'b1, 1'b1});
        op_exp(4'b0011, 4'b0101, 1'b0, MODE_SUB, {4'b1110, 1'b0, 1'b0});
        op_exp(4'b0101, 4'b0101, 1'b1, MODE_SUB, {4'b1111, 1'b0, 1'b0});
        op_exp(4'b0111, 4'b0001, 1'b0, MODE_ADD, {4'b1000, 1'b0, 1'b1});
        op_exp(4'b1000, 4'b0001, 1'b0, MODE_SUB, {4'b0111, 1'b1, 1'b1});
        op_exp(4'b1111, 4'b0000, 1'b1, MODE_ADD, {4'b0000, 1'b1, 1'b0});

        // Single-cycle pulse, then outputs must hold.
        idle(2);
        op_exp(4'b0110, 4'b0011, 1'b1, MODE_ADD, {4'b1010, 1'b0, 1'b1});
        idle(3);
        cmp("hold_S", {4'h0, S}, {4'h0, last_exp.s});
        cmp("hold_Co", {7'h0, Co}, {7'h0, last_exp.co});
        cmp("idle_vld", {7'h0, out_valid}, 8'h00);

        // Reset asserted mid-stream: clears without a clock, in-flight ops are dropped.
        op(4'b0101, 4'b0110, 1'b0, MODE_ADD);
        op(4'b1101, 4'b0010, 1'b1, MODE_SUB);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        cmp("async_rst_S", {4'h0, S}, 8'h00);
        cmp("async_rst_Co", {7'h0, Co}, 8'h00);
        cmp("async_rst_vld", {7'h0, out_valid}, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        cmp("post_rst_vld", {7'h0, out_valid}, 8'h00);
        op_exp(4'b0010, 4'b0011, 1'b0, MODE_ADD, {4'b0101, 1'b0, 1'b0});
        idle(2);

        // Exhaustive 4-bit sweep, back-to-back.
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        op(a[W-1:0], b[W-1:0], c[0], m[0]);
        idle(4);
        cmp("drain", sb.size(), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
